// File: rtl/bt_tx_sched.sv
// ============================================================================
// bt_tx_sched : Bluetooth module boot, link tracking and 3-way round-robin
//               UART (8N1) byte transmitter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bt_tx_sched #(
    parameter int BAUD_DIV   = 10417,
    parameter int RST_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       status_in,
    input  logic [2:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    output logic [2:0] gnt,
    output logic       txd,
    output logic       bt_rst_n,
    output logic       link_up,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    localparam int c_BIT_W  = $clog2(BAUD_DIV + 1);
    localparam int c_BOOT_W = $clog2(RST_CYCLES + 1);
    localparam logic [c_BIT_W-1:0]  c_BAUD_LAST = c_BIT_W'(BAUD_DIV - 1);
    localparam logic [c_BOOT_W-1:0] c_BOOT_LAST = c_BOOT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_BOOT      = 3'd0,
        S_WAIT_LINK = 3'd1,
        S_IDLE      = 3'd2,
        S_START     = 3'd3,
        S_DATA      = 3'd4,
        S_STOP      = 3'd5
    } state_t;

    state_t                r_state;
    logic [c_BOOT_W-1:0]   r_boot_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic [1:0]            r_last_winner;
    logic                  r_sync1;

    logic [1:0]            w_win_idx;
    logic [7:0]            w_win_byte;
    logic                  w_bit_end;

    // Walk the candidates from farthest to nearest so the nearest requester
    // after the last winner is the one left standing.
    always_comb begin
        w_win_idx = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (req[(int'(r_last_winner) + 1 + k) % 3]) begin
                w_win_idx = 2'((int'(r_last_winner) + 1 + k) % 3);
            end
        end
    end

    always_comb begin
        case (w_win_idx)
            2'd1:    w_win_byte = data1;
            2'd2:    w_win_byte = data2;
            default: w_win_byte = data0;
        endcase
    end

    assign w_bit_end = (r_bit_cnt == c_BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_boot_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_last_winner <= 2'd2;
            r_sync1       <= 1'b0;
            link_up       <= 1'b0;
            txd           <= 1'b1;
            bt_rst_n      <= 1'b0;
            gnt           <= '0;
            busy          <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            r_sync1 <= status_in;
            link_up <= r_sync1;
            gnt     <= '0;
            case (r_state)
                S_BOOT: begin
                    if (r_boot_cnt == c_BOOT_LAST) begin
                        bt_rst_n <= 1'b1;
                        r_state  <= S_WAIT_LINK;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 1'b1;
                    end
                end
                S_WAIT_LINK: begin
                    if (link_up) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (!link_up) begin
                        r_state <= S_WAIT_LINK;
                    end else if (|req) begin
                        r_shift       <= w_win_byte;
                        gnt           <= 3'(3'b001 << w_win_idx);
                        r_last_winner <= w_win_idx;
                        txd           <= 1'b0;
                        busy          <= 1'b1;
                        r_bit_cnt     <= '0;
                        r_bit_idx     <= '0;
                        r_state       <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        txd       <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_state   <= S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            txd     <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            txd       <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                        // A link lost mid-frame is only acted on once the frame is out.
                        r_state   <= link_up ? S_IDLE : S_WAIT_LINK;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bt_tx_sched.sv
// ============================================================================
// tb_bt_tx_sched : directed, table-driven bench for bt_tx_sched.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_bt_tx_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       status_in;
    logic [2:0] req;
    logic [7:0] data0, data1, data2;
    logic [2:0] gnt;
    logic       txd, bt_rst_n, link_up, busy;
    logic [7:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_gnt_cyc = 0;
    bit have_prev = 1'b0;
    logic [7:0] exp_fc = 8'd0;

    typedef struct {
        logic [2:0] req;
        logic [7:0] d0, d1, d2;
        logic [2:0] exp_gnt;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[8];

    bt_tx_sched #(.BAUD_DIV(4), .RST_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .status_in (status_in),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .gnt       (gnt),
        .txd       (txd),
        .bt_rst_n  (bt_rst_n),
        .link_up   (link_up),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at the negedge just after the last reset edge, with rst_n released.
    task automatic boot_check();
        int low = 0;
        int bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bt_rst_n !== 1'b0) break;
            low++;
            if (gnt !== 3'b000 || txd !== 1'b1) bad++;
            @(negedge clk);
        end
        check("boot_low_cycles", low, 8);
        check("boot_quiet", bad, 0);
    endtask

    task automatic wait_gnt(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (gnt !== 3'b000) begin
                found = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Waits for a grant, then checks the whole 40-cycle frame sample by sample.
    task automatic send_check(input logic [2:0] eg, input logic [7:0] eb, input int drop_at);
        logic [9:0] wave;
        bit found;
        int wave_err = 0;
        int busy_err = 0;
        int gnt_err  = 0;
        wave = {1'b1, eb, 1'b0};
        wait_gnt(found);
        if (!found) begin
            check("gnt_timeout", 0, 1);
            return;
        end
        check("gnt", gnt, eg);
        if (have_prev) check("gnt_spacing_ge41", (cyc - last_gnt_cyc) >= 41, 1);
        have_prev    = 1'b1;
        last_gnt_cyc = cyc;
        for (int i = 0; i < 40; i++) begin
            if (i == drop_at) status_in = 1'b0;
            if (txd !== wave[i / 4]) wave_err++;
            if (busy !== 1'b1) busy_err++;
            if (i > 0 && gnt !== 3'b000) gnt_err++;
            @(negedge clk);
        end
        exp_fc = exp_fc + 8'd1;
        check("txd_wave", wave_err, 0);
        check("busy_high", busy_err, 0);
        check("gnt_one_cycle", gnt_err, 0);
        check("busy_after", busy, 0);
        check("txd_idle_after", txd, 1);
        check("frame_cnt", frame_cnt, exp_fc);
    endtask

    initial begin
        int nog;
        vecs[0] = '{3'b001, 8'h58, 8'h00, 8'h00, 3'b001, 8'h58};
        vecs[1] = '{3'b111, 8'hA5, 8'h3C, 8'hC3, 3'b010, 8'h3C};
        vecs[2] = '{3'b111, 8'hA5, 8'h3C, 8'hC3, 3'b100, 8'hC3};
        vecs[3] = '{3'b111, 8'hA5, 8'h3C, 8'hC3, 3'b001, 8'hA5};
        vecs[4] = '{3'b101, 8'h01, 8'h00, 8'h80, 3'b100, 8'h80};
        vecs[5] = '{3'b011, 8'hFF, 8'h00, 8'h00, 3'b001, 8'hFF};
        vecs[6] = '{3'b001, 8'h6E, 8'h00, 8'h00, 3'b001, 8'h6E};
        vecs[7] = '{3'b110, 8'h00, 8'h12, 8'h34, 3'b010, 8'h12};

        rst_n = 1'b0; status_in = 1'b1; req = 3'b000;
        data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_bt_rst_n", bt_rst_n, 0);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_link_up", link_up, 0);
        rst_n = 1'b1;
        boot_check();

        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            data0 = vecs[i].d0; data1 = vecs[i].d1; data2 = vecs[i].d2;
            send_check(vecs[i].exp_gnt, vecs[i].exp_byte, -1);
        end

        // Link lost during DATA bit 3: frame finishes, then no grants.
        req = 3'b010; data1 = 8'h96;
        send_check(3'b010, 8'h96, 17);
        nog = 0;
        for (int i = 0; i < 30; i++) begin
            if (gnt !== 3'b000) nog++;
            @(negedge clk);
        end
        check("no_gnt_link_down", nog, 0);
        check("busy_link_down", busy, 0);
        status_in = 1'b1;
        send_check(3'b010, 8'h96, -1);

        // Reset pulse in the middle of DATA.
        req = 3'b001; data0 = 8'h55;
        begin
            bit found;
            wait_gnt(found);
            check("midrst_gnt_seen", found, 1);
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_txd", txd, 1);
        check("midrst_busy", busy, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_bt_rst_n", bt_rst_n, 0);
        check("midrst_link_up", link_up, 0);
        rst_n = 1'b1;
        boot_check();
        exp_fc = 8'd0;
        have_prev = 1'b0;

        // Fresh round-robin after reset: 0,1,2,0.
        req = 3'b111; data0 = 8'h11; data1 = 8'h22; data2 = 8'h33;
        send_check(3'b001, 8'h11, -1);
        send_check(3'b010, 8'h22, -1);
        send_check(3'b100, 8'h33, -1);
        send_check(3'b001, 8'h11, -1);

        // Run the frame counter around to zero.
        req = 3'b001;
        for (int i = 0; i < 252; i++) begin
            data0 = 8'(i * 7 + 3);
            send_check(3'b001, 8'(i * 7 + 3), -1);
        end
        check("frame_cnt_wrap", frame_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
